// File: rtl/cache_seq_driver.sv
// cache_seq_driver
//   Request initiator and self-checker for a small cache responder. After an
//   accepted start it walks four phases over every entry (write P, read P,
//   write ~P, read ~P), issuing one registered request per ISSUE cycle and
//   checking the registered response in the following CHECK cycle.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     start, seed       run request (IDLE only), pattern seed
//     req_valid/rw/addr/data   request bundle to the cache (registered)
//     rsp_hit, rsp_data         registered cache response
//     busy, done, pass          run status (done is sticky until next start)
//     hit_count, err_count      saturating per-run counters
//
//   state | meaning
//   IDLE  | waiting for start; results of the last run held
//   ISSUE | request on the bus for exactly one cycle
//   CHECK | response sampled, counters updated, next request loaded
module cache_seq_driver #(
    parameter int NUM_ENTRIES = 4,
    parameter int ADDR_W      = 2,
    parameter int DATA_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              req_valid,
    output logic              req_rw,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_data,
    input  logic              rsp_hit,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [4:0]        hit_count,
    output logic [4:0]        err_count
);

    localparam int OPS  = 4 * NUM_ENTRIES;
    localparam int OP_W = ADDR_W + 2;

    typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;

    state_t            state, state_nxt;
    logic [OP_W-1:0]   op_idx, op_idx_nxt;
    logic [DATA_W-1:0] seed_q, seed_q_nxt;
    logic              req_valid_nxt, req_rw_nxt;
    logic [ADDR_W-1:0] req_addr_nxt;
    logic [DATA_W-1:0] req_data_nxt;
    logic              busy_nxt, done_nxt;
    logic [4:0]        hit_count_nxt, err_count_nxt;

    // Op index layout: upper two bits are the phase, lower bits the address.
    logic [OP_W-1:0]   ld_op;
    logic [DATA_W-1:0] ld_seed, ld_pat;
    logic [1:0]        ld_phase, ck_phase;
    logic [ADDR_W-1:0] ld_addr, ck_addr;
    logic [DATA_W-1:0] ck_pat, ck_exp_data;
    logic              ck_exp_hit, ck_is_read, ck_err, last_op;

    // The load path serves both the op 0 load in IDLE (seed not yet captured)
    // and the next-op load in CHECK.
    assign ld_op    = (state == IDLE) ? '0 : op_idx + OP_W'(1);
    assign ld_seed  = (state == IDLE) ? seed : seed_q;
    assign ld_phase = ld_op[OP_W-1 -: 2];
    assign ld_addr  = ld_op[ADDR_W-1:0];
    assign ld_pat   = DATA_W'(ld_addr) + ld_seed;

    assign ck_phase    = op_idx[OP_W-1 -: 2];
    assign ck_addr     = op_idx[ADDR_W-1:0];
    assign ck_pat      = DATA_W'(ck_addr) + seed_q;
    assign ck_exp_hit  = (ck_phase != 2'd0);
    assign ck_is_read  = ck_phase[0];
    assign ck_exp_data = (ck_phase == 2'd3) ? ~ck_pat : ck_pat;
    assign ck_err      = (rsp_hit != ck_exp_hit) ||
                         (ck_is_read && (rsp_data != ck_exp_data));
    assign last_op     = (op_idx == OP_W'(OPS - 1));

    assign pass = done && (err_count == 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_idx    <= '0;
            seed_q    <= '0;
            req_valid <= 1'b0;
            req_rw    <= 1'b0;
            req_addr  <= '0;
            req_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit_count <= 5'd0;
            err_count <= 5'd0;
        end else begin
            state     <= state_nxt;
            op_idx    <= op_idx_nxt;
            seed_q    <= seed_q_nxt;
            req_valid <= req_valid_nxt;
            req_rw    <= req_rw_nxt;
            req_addr  <= req_addr_nxt;
            req_data  <= req_data_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            hit_count <= hit_count_nxt;
            err_count <= err_count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   state_nxt = CHECK;
            CHECK:   state_nxt = last_op ? IDLE : ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        op_idx_nxt    = op_idx;
        seed_q_nxt    = seed_q;
        req_valid_nxt = 1'b0;
        req_rw_nxt    = req_rw;
        req_addr_nxt  = req_addr;
        req_data_nxt  = req_data;
        busy_nxt      = busy;
        done_nxt      = done;
        hit_count_nxt = hit_count;
        err_count_nxt = err_count;

        case (state)
            IDLE: begin
                if (start) begin
                    seed_q_nxt    = seed;
                    hit_count_nxt = 5'd0;
                    err_count_nxt = 5'd0;
                    done_nxt      = 1'b0;
                    busy_nxt      = 1'b1;
                    op_idx_nxt    = '0;
                end
            end
            CHECK: begin
                if (rsp_hit && hit_count != 5'd31)
                    hit_count_nxt = hit_count + 5'd1;
                if (ck_err && err_count != 5'd31)
                    err_count_nxt = err_count + 5'd1;
                if (last_op) begin
                    busy_nxt = 1'b0;
                    done_nxt = 1'b1;
                end else begin
                    op_idx_nxt = ld_op;
                end
            end
            default: ;
        endcase

        if ((state == IDLE && start) || (state == CHECK && !last_op)) begin
            req_valid_nxt = 1'b1;
            req_rw_nxt    = ~ld_phase[0];
            req_addr_nxt  = ld_addr;
            case (ld_phase)
                2'd0:    req_data_nxt = ld_pat;
                2'd2:    req_data_nxt = ~ld_pat;
                default: req_data_nxt = '0;
            endcase
        end
    end

endmodule
